// File: rtl/cook_controller.sv
// cook_controller: microwave timer sequencer handling keypad digit shifts, the 1 Hz count enable,
// door interlock, pause/resume, and the end-of-cook beep.
module cook_controller #(
  parameter int TICK_DIV   = 100,
  parameter int BEEP_SECS  = 3,
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  input  logic       timer_zero,
  output logic       timer_loadn,
  output logic [3:0] timer_data,
  output logic       timer_en,
  output logic       timer_clrn,
  output logic       mag_on,
  output logic       beep,
  output logic [2:0] state
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int BW = $clog2(BEEP_SECS + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, ENTRY = 3'd1, COOK = 3'd2, PAUSE = 3'd3, DONE = 3'd4} st_t;
  st_t st_q, st_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [3:0] data_q, data_d;
  logic loadn_q, loadn_d, en_q, en_d, clrn_q, mag_q, beep_q, clr, tick, dig;
  assign tick = pre_q == PW'(TICK_DIV - 1);
  assign dig = key_valid && key_code <= 4'd9 && cnt_q < CW'(MAX_DIGITS);
  always_comb begin
    st_d = st_q;
    pre_d = pre_q;
    cnt_d = cnt_q;
    bcnt_d = bcnt_q;
    loadn_d = 1'b1;
    data_d = '0;
    en_d = 1'b0;
    clr = 1'b0;
    case (st_q)
      IDLE, ENTRY:
        if (stop_clear) clr = 1'b1;
        else if (st_q == ENTRY && start && door_closed && !timer_zero) begin
          st_d = COOK;
          pre_d = '0;
        end else if (dig) begin
          loadn_d = 1'b0;
          data_d = key_code;
          cnt_d = cnt_q + CW'(1);
          st_d = ENTRY;
        end
      COOK:
        if (stop_clear || !door_closed) st_d = PAUSE;
        // a zero flag seen alongside an enable pulse is stale; wait for the decrement
        else if (timer_zero && !en_q) begin
          st_d = DONE;
          pre_d = '0;
          bcnt_d = '0;
        end else begin
          pre_d = tick ? '0 : pre_q + PW'(1);
          en_d = tick;
        end
      PAUSE:
        if (stop_clear) clr = 1'b1;
        else if (start && door_closed) st_d = COOK;
      DONE:
        if (start || stop_clear || key_valid || (tick && bcnt_q == BW'(BEEP_SECS - 1))) clr = 1'b1;
        else begin
          pre_d = tick ? '0 : pre_q + PW'(1);
          bcnt_d = bcnt_q + BW'(tick);
        end
      default: st_d = IDLE;
    endcase
    if (clr) begin
      st_d = IDLE;
      cnt_d = '0;
      pre_d = '0;
    end
  end
  always_ff @(posedge clk or negedge clearn)
    if (!clearn) begin
      st_q <= IDLE;
      pre_q <= '0;
      cnt_q <= '0;
      bcnt_q <= '0;
      loadn_q <= 1'b1;
      data_q <= '0;
      en_q <= 1'b0;
      clrn_q <= 1'b0;
      mag_q <= 1'b0;
      beep_q <= 1'b0;
    end else begin
      st_q <= st_d;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      bcnt_q <= bcnt_d;
      loadn_q <= loadn_d;
      data_q <= data_d;
      en_q <= en_d;
      clrn_q <= !clr;
      mag_q <= st_d == COOK;
      beep_q <= st_d == DONE;
    end
  assign timer_loadn = loadn_q;
  assign timer_data = data_q;
  assign timer_en = en_q;
  assign timer_clrn = clrn_q;
  assign mag_on = mag_q;
  assign beep = beep_q;
  assign state = st_q;
endmodule

// File: tb/tb_cook_controller.sv
// tb_cook_controller: directed checks of cook_controller with a small countdown-timer model.
module tb_cook_controller;
  logic clk = 1'b0;
  logic clearn, key_valid, start, stop_clear, door_closed, timer_zero;
  logic [3:0] key_code;
  logic timer_loadn, timer_en, timer_clrn, mag_on, beep;
  logic [3:0] timer_data;
  logic [2:0] state;
  int checks = 0, errors = 0, rem = 9;
  assign timer_zero = rem == 0;
  always #5 clk = ~clk;
  cook_controller #(.TICK_DIV(4), .BEEP_SECS(3), .MAX_DIGITS(3)) dut (
    .clk(clk), .clearn(clearn), .key_valid(key_valid), .key_code(key_code), .start(start),
    .stop_clear(stop_clear), .door_closed(door_closed), .timer_zero(timer_zero),
    .timer_loadn(timer_loadn), .timer_data(timer_data), .timer_en(timer_en),
    .timer_clrn(timer_clrn), .mag_on(mag_on), .beep(beep), .state(state)
  );
  // the timer model counts down once per enable pulse seen during a cycle
  task automatic cyc(input int n);
    logic e;
    for (int i = 0; i < n; i++) begin
      e = timer_en;
      @(posedge clk);
      if (e && rem > 0) rem--;
      #1;
    end
  endtask
  task automatic key(input logic [3:0] c);
    key_valid = 1'b1;
    key_code = c;
    cyc(1);
    key_valid = 1'b0;
  endtask
  task automatic test_reset;
    clearn = 1'b0;
    cyc(2);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
    checks++; if (timer_loadn !== 1'b1) begin errors++; $display("FAIL rst_loadn got %b exp 1", timer_loadn); end
    checks++; if (timer_data !== 4'd0) begin errors++; $display("FAIL rst_data got %0d exp 0", timer_data); end
    checks++; if (timer_clrn !== 1'b0) begin errors++; $display("FAIL rst_clrn got %b exp 0", timer_clrn); end
    checks++; if ({timer_en, mag_on, beep} !== 3'b000) begin errors++; $display("FAIL rst_en_mag_beep got %b exp 000", {timer_en, mag_on, beep}); end
    clearn = 1'b1;
    cyc(1);
    checks++; if (timer_clrn !== 1'b1) begin errors++; $display("FAIL rst_release_clrn got %b exp 1", timer_clrn); end
  endtask
  task automatic test_entry;
    logic [3:0] codes [3];
    codes = '{4'd1, 4'd3, 4'd0};
    for (int i = 0; i < 3; i++) begin
      key(codes[i]);
      checks++; if ({timer_loadn, timer_data} !== {1'b0, codes[i]}) begin errors++; $display("FAIL entry_pulse%0d got %b/%0d exp 0/%0d", i, timer_loadn, timer_data, codes[i]); end
      cyc(1);
      checks++; if (timer_loadn !== 1'b1) begin errors++; $display("FAIL entry_width%0d got %b exp 1", i, timer_loadn); end
    end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL entry_state got %0d exp 1", state); end
    key(4'd7);
    checks++; if (timer_loadn !== 1'b1) begin errors++; $display("FAIL entry_sat got %b exp 1", timer_loadn); end
    stop_clear = 1'b1;
    cyc(1);
    stop_clear = 1'b0;
    checks++; if ({state, timer_clrn} !== {3'd0, 1'b0}) begin errors++; $display("FAIL entry_clear got %0d/%b exp 0/0", state, timer_clrn); end
    key(4'd12);
    checks++; if ({state, timer_loadn} !== {3'd0, 1'b1}) begin errors++; $display("FAIL entry_badcode got %0d/%b exp 0/1", state, timer_loadn); end
  endtask
  task automatic test_cook;
    int en_n, first_en, done_k, beep_n, clr_k;
    rem = 2;
    key(4'd0);
    key(4'd0);
    key(4'd2);
    checks++; if ({timer_loadn, timer_data} !== {1'b0, 4'd2}) begin errors++; $display("FAIL cook_load got %b/%0d exp 0/2", timer_loadn, timer_data); end
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    checks++; if ({state, mag_on, timer_en} !== {3'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL cook_start got %0d/%b/%b exp 2/1/0", state, mag_on, timer_en); end
    en_n = 0; first_en = -1; done_k = -1; beep_n = 0; clr_k = -1;
    for (int k = 1; k <= 24; k++) begin
      cyc(1);
      if (timer_en) en_n++;
      if (timer_en && first_en < 0) first_en = k;
      if (state == 3'd4 && done_k < 0) done_k = k;
      if (beep) beep_n++;
      if (!timer_clrn && clr_k < 0) clr_k = k;
    end
    checks++; if (first_en !== 4) begin errors++; $display("FAIL cook_first_en got %0d exp 4", first_en); end
    checks++; if (en_n !== 2) begin errors++; $display("FAIL cook_en_count got %0d exp 2", en_n); end
    checks++; if (done_k !== 10) begin errors++; $display("FAIL cook_done_cycle got %0d exp 10", done_k); end
    checks++; if (beep_n !== 12) begin errors++; $display("FAIL cook_beep_len got %0d exp 12", beep_n); end
    checks++; if (clr_k !== 22) begin errors++; $display("FAIL cook_clr_cycle got %0d exp 22", clr_k); end
    checks++; if ({state, mag_on, beep} !== {3'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL cook_end got %0d/%b/%b exp 0/0/0", state, mag_on, beep); end
  endtask
  task automatic test_pause_resume;
    int en_seen;
    rem = 5;
    key(4'd5);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    door_closed = 1'b0;
    cyc(1);
    checks++; if ({state, mag_on} !== {3'd3, 1'b0}) begin errors++; $display("FAIL pause_door got %0d/%b exp 3/0", state, mag_on); end
    en_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (timer_en) en_seen++;
    end
    checks++; if (en_seen !== 0) begin errors++; $display("FAIL pause_no_en got %0d exp 0", en_seen); end
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL pause_start_open got %0d exp 3", state); end
    door_closed = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    checks++; if ({state, mag_on} !== {3'd2, 1'b1}) begin errors++; $display("FAIL resume got %0d/%b exp 2/1", state, mag_on); end
    cyc(1);
    checks++; if (timer_en !== 1'b0) begin errors++; $display("FAIL resume_en1 got %b exp 0", timer_en); end
    cyc(1);
    checks++; if (timer_en !== 1'b1) begin errors++; $display("FAIL resume_en2 got %b exp 1", timer_en); end
    stop_clear = 1'b1;
    cyc(1);
    stop_clear = 1'b0;
    checks++; if ({state, mag_on, timer_clrn} !== {3'd3, 1'b0, 1'b1}) begin errors++; $display("FAIL stop_cook got %0d/%b/%b exp 3/0/1", state, mag_on, timer_clrn); end
    stop_clear = 1'b1;
    cyc(1);
    stop_clear = 1'b0;
    checks++; if ({state, timer_clrn} !== {3'd0, 1'b0}) begin errors++; $display("FAIL stop_pause got %0d/%b exp 0/0", state, timer_clrn); end
  endtask
  task automatic test_priority;
    rem = 5;
    key(4'd4);
    start = 1'b1;
    stop_clear = 1'b1;
    cyc(1);
    start = 1'b0;
    stop_clear = 1'b0;
    checks++; if ({state, timer_clrn, mag_on} !== {3'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL prio_clear got %0d/%b/%b exp 0/0/0", state, timer_clrn, mag_on); end
    cyc(1);
    checks++; if (timer_clrn !== 1'b1) begin errors++; $display("FAIL prio_clrn_width got %b exp 1", timer_clrn); end
    key(4'd4);
    rem = 0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    checks++; if ({state, mag_on} !== {3'd1, 1'b0}) begin errors++; $display("FAIL start_zero got %0d/%b exp 1/0", state, mag_on); end
    stop_clear = 1'b1;
    cyc(1);
    stop_clear = 1'b0;
  endtask
  task automatic test_done_abort;
    int k;
    rem = 1;
    key(4'd1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    k = 0;
    while (state != 3'd4 && k < 20) begin
      cyc(1);
      k++;
    end
    checks++; if ({state, beep} !== {3'd4, 1'b1}) begin errors++; $display("FAIL done_reach got %0d/%b exp 4/1", state, beep); end
    key(4'd5);
    checks++; if ({state, beep, timer_loadn, timer_clrn} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin errors++; $display("FAIL done_abort got %0d/%b/%b/%b exp 0/0/1/0", state, beep, timer_loadn, timer_clrn); end
  endtask
  task automatic test_reset_mid;
    rem = 3;
    key(4'd3);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(2);
    #3 clearn = 1'b0;
    #1;
    checks++; if ({state, mag_on, timer_clrn, timer_loadn, timer_en, beep} !== {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL mid_reset got %0d/%b/%b/%b/%b/%b exp 0/0/0/1/0/0", state, mag_on, timer_clrn, timer_loadn, timer_en, beep); end
    cyc(1);
    clearn = 1'b1;
    cyc(1);
    checks++; if ({state, timer_clrn, mag_on} !== {3'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL mid_release got %0d/%b/%b exp 0/1/0", state, timer_clrn, mag_on); end
  endtask
  initial begin
    key_valid = 1'b0;
    key_code = 4'd0;
    start = 1'b0;
    stop_clear = 1'b0;
    door_closed = 1'b1;
    test_reset();
    test_entry();
    test_cook();
    test_pause_resume();
    test_priority();
    test_done_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
